// File: rtl/ps2_pkg.sv
// Shared constants and state encodings for the PS/2 keypad path.
package ps2_pkg;

    // Set-2 scan codes used by the paddle decoder
    localparam logic [7:0] SC_EXT  = 8'hE0;
    localparam logic [7:0] SC_BRK  = 8'hF0;
    localparam logic [7:0] SC_W    = 8'h1D;
    localparam logic [7:0] SC_S    = 8'h1B;
    localparam logic [7:0] SC_UP   = 8'h75;
    localparam logic [7:0] SC_DOWN = 8'h72;

    // Frame receiver states
    typedef enum logic [1:0] {
        RX_IDLE   = 2'd0,
        RX_DATA   = 2'd1,
        RX_PARITY = 2'd2,
        RX_STOP   = 2'd3
    } rx_state_t;

    // Scan-code prefix tracker states
    typedef enum logic [1:0] {
        DEC_NORM    = 2'd0,
        DEC_EXT     = 2'd1,
        DEC_BRK     = 2'd2,
        DEC_EXT_BRK = 2'd3
    } dec_state_t;

    // Odd parity holds when data plus parity bit carry an odd number of ones
    function automatic logic odd_parity_ok(input logic [7:0] d, input logic p);
        return ^{d, p};
    endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host frame receiver: synchronizer, clock glitch filter,
// 11-bit frame FSM with parity/stop checking and an inter-edge timeout.
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       err
);

    localparam int FCW = $clog2(FILTER_LEN + 1);
    localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);

    logic [1:0]     clk_sync, dat_sync;
    logic           clk_s, dat_s;
    logic           filt, filt_d, fall;
    logic [FCW-1:0] filt_cnt;

    rx_state_t      state, state_n;
    logic [7:0]     shreg, shreg_n;
    logic [2:0]     bit_cnt, bit_cnt_n;
    logic           par, par_n;
    logic [TCW-1:0] to_cnt, to_cnt_n;

    assign clk_s   = clk_sync[1];
    assign dat_s   = dat_sync[1];
    assign fall    = filt_d & ~filt;
    assign rx_byte = shreg;

    // Two-flop synchronizers; both lines idle high
    always_ff @(posedge clk) begin
        if (!reset) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
        end else begin
            clk_sync <= {clk_sync[0], ps2_clk};
            dat_sync <= {dat_sync[0], ps2_data};
        end
    end

    // Accept a new clock level only after FILTER_LEN consecutive differing samples
    always_ff @(posedge clk) begin
        if (!reset) begin
            filt     <= 1'b1;
            filt_d   <= 1'b1;
            filt_cnt <= '0;
        end else begin
            filt_d <= filt;
            if (clk_s == filt) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FCW'(FILTER_LEN - 1)) begin
                filt     <= clk_s;
                filt_cnt <= '0;
            end else begin
                filt_cnt <= filt_cnt + FCW'(1);
            end
        end
    end

    // Frame state register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= RX_IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
            par     <= 1'b0;
            to_cnt  <= '0;
        end else begin
            state   <= state_n;
            shreg   <= shreg_n;
            bit_cnt <= bit_cnt_n;
            par     <= par_n;
            to_cnt  <= to_cnt_n;
        end
    end

    // Frame next-state, sampling on each filtered fall, and error detection
    always_comb begin
        state_n    = state;
        shreg_n    = shreg;
        bit_cnt_n  = bit_cnt;
        par_n      = par;
        to_cnt_n   = '0;
        byte_valid = 1'b0;
        err        = 1'b0;

        if (state != RX_IDLE && !fall)
            to_cnt_n = to_cnt + TCW'(1);

        case (state)
            RX_IDLE: begin
                // A high start bit is treated as line noise, not an error
                if (fall && !dat_s) begin
                    state_n   = RX_DATA;
                    bit_cnt_n = '0;
                end
            end
            RX_DATA: begin
                if (fall) begin
                    shreg_n   = {dat_s, shreg[7:1]};
                    bit_cnt_n = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7)
                        state_n = RX_PARITY;
                end
            end
            RX_PARITY: begin
                if (fall) begin
                    par_n   = dat_s;
                    state_n = RX_STOP;
                end
            end
            RX_STOP: begin
                if (fall) begin
                    if (odd_parity_ok(shreg, par) && dat_s)
                        byte_valid = 1'b1;
                    else
                        err = 1'b1;
                    state_n = RX_IDLE;
                end
            end
            default: state_n = RX_IDLE;
        endcase

        // A stalled frame is dropped; a fall in the same cycle restarts the count instead
        if (state != RX_IDLE && !fall && to_cnt == TCW'(TIMEOUT_CYCLES - 1)) begin
            err      = 1'b1;
            state_n  = RX_IDLE;
            to_cnt_n = '0;
        end
    end

endmodule

// File: rtl/ps2_keypad_decoder.sv
// PS/2 keyboard to paddle-control decoder: tracks E0/F0 prefixes and holds
// the W/S/Up/Down key levels for the game core.
module ps2_keypad_decoder
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       p1u,
    output logic       p1d,
    output logic       p2u,
    output logic       p2d,
    output logic [7:0] code,
    output logic       code_valid,
    output logic       frame_err
);

    logic [7:0] rx_byte;
    logic       byte_valid, rx_err;

    dec_state_t dec, dec_n;
    // Key bit order: {p2d, p2u, p1d, p1u}
    logic [3:0] keys, keys_n;
    logic       apply, ext, make;

    ps2_frame_rx #(
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_rx (
        .clk        (clk),
        .reset      (reset),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .rx_byte    (rx_byte),
        .byte_valid (byte_valid),
        .err        (rx_err)
    );

    assign {p2d, p2u, p1d, p1u} = keys;

    // Decoder state, key levels and the registered byte/strobe outputs share one edge
    always_ff @(posedge clk) begin
        if (!reset) begin
            dec        <= DEC_NORM;
            keys       <= '0;
            code       <= '0;
            code_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            dec        <= dec_n;
            keys       <= keys_n;
            code_valid <= byte_valid;
            frame_err  <= rx_err;
            if (byte_valid)
                code <= rx_byte;
        end
    end

    // Prefix tracking and make/break application to the mapped keys
    always_comb begin
        dec_n  = dec;
        keys_n = keys;
        apply  = 1'b0;
        ext    = 1'b0;
        make   = 1'b0;

        if (byte_valid) begin
            case (dec)
                DEC_NORM: begin
                    if (rx_byte == SC_EXT) begin
                        dec_n = DEC_EXT;
                    end else if (rx_byte == SC_BRK) begin
                        dec_n = DEC_BRK;
                    end else begin
                        apply = 1'b1;
                        make  = 1'b1;
                    end
                end
                DEC_EXT: begin
                    if (rx_byte == SC_BRK) begin
                        dec_n = DEC_EXT_BRK;
                    end else begin
                        dec_n = DEC_NORM;
                        apply = 1'b1;
                        ext   = 1'b1;
                        make  = 1'b1;
                    end
                end
                DEC_BRK: begin
                    dec_n = DEC_NORM;
                    apply = 1'b1;
                end
                DEC_EXT_BRK: begin
                    dec_n = DEC_NORM;
                    apply = 1'b1;
                    ext   = 1'b1;
                end
                default: dec_n = DEC_NORM;
            endcase
        end

        // Plain 0x75 is keypad 8 and must not touch the Up arrow
        if (apply) begin
            if (!ext && rx_byte == SC_W)    keys_n[0] = make;
            if (!ext && rx_byte == SC_S)    keys_n[1] = make;
            if ( ext && rx_byte == SC_UP)   keys_n[2] = make;
            if ( ext && rx_byte == SC_DOWN) keys_n[3] = make;
        end
    end

endmodule

// File: tb/tb_ps2_keypad_decoder.sv
// Directed bench for ps2_keypad_decoder: PS/2 frames at 40 clk per bit.
`timescale 1ns/1ps
module tb_ps2_keypad_decoder;

    localparam int TO = 2000;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       p1u, p1d, p2u, p2d;
    logic [7:0] code;
    logic       code_valid, frame_err;

    int tests_run = 0;
    int tests_failed = 0;
    int cv_cycles = 0;
    int err_cycles = 0;
    logic [3:0] keys_at_cv = 4'h0;
    logic [7:0] code_at_cv = 8'h00;

    always #1 clk = ~clk;

    ps2_keypad_decoder #(.FILTER_LEN(8), .TIMEOUT_CYCLES(TO)) dut (
        .clk        (clk),
        .reset      (reset),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .p1u        (p1u),
        .p1d        (p1d),
        .p2u        (p2u),
        .p2d        (p2d),
        .code       (code),
        .code_valid (code_valid),
        .frame_err  (frame_err)
    );

    // Pulse monitor, sampled away from the active edge
    always @(negedge clk) begin
        if (reset) begin
            if (code_valid === 1'b1) begin
                cv_cycles++;
                keys_at_cv = {p2d, p2u, p1d, p1u};
                code_at_cv = code;
            end
            if (frame_err === 1'b1) err_cycles++;
        end else if (code_valid !== 1'b0 || frame_err !== 1'b0) begin
            cv_cycles++;
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
    endtask

    function automatic logic [10:0] mk_frame(input logic [7:0] d, input bit bad_par);
        logic p;
        p = ~(^d) ^ bad_par;
        return {1'b1, p, d, 1'b0};
    endfunction

    // Device-to-host bits: data changes mid-high, host samples on the fall
    task automatic send_bits(input logic [10:0] f, input int n, input bit glitch);
        for (int i = 0; i < n; i++) begin
            wait_clk(5);
            ps2_data = f[i];
            if (glitch) begin
                wait_clk(1); ps2_clk = 1'b0; wait_clk(3); ps2_clk = 1'b1; wait_clk(1);
            end else begin
                wait_clk(5);
            end
            ps2_clk = 1'b0;
            if (glitch) begin
                wait_clk(8); ps2_clk = 1'b1; wait_clk(3); ps2_clk = 1'b0; wait_clk(9);
            end else begin
                wait_clk(20);
            end
            ps2_clk = 1'b1;
            wait_clk(10);
        end
        ps2_data = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] d);
        send_bits(mk_frame(d, 1'b0), 11, 1'b0);
        wait_clk(20);
    endtask

    task automatic test_reset;
        reset = 1'b0;
        wait_clk(6);
        @(negedge clk);
        tests_run++;
        if ({p2d, p2u, p1d, p1u} !== 4'b0000) begin
            tests_failed++; $display("FAIL reset_keys: got %b want 0000", {p2d, p2u, p1d, p1u});
        end
        tests_run++;
        if (code !== 8'h00) begin
            tests_failed++; $display("FAIL reset_code: got %h want 00", code);
        end
        tests_run++;
        if (code_valid !== 1'b0 || frame_err !== 1'b0) begin
            tests_failed++; $display("FAIL reset_pulses: got cv=%b err=%b want 0 0", code_valid, frame_err);
        end
        reset = 1'b1;
        wait_clk(20);
    endtask

    task automatic test_make_w;
        int cv0, e0;
        cv0 = cv_cycles; e0 = err_cycles;
        send_byte(8'h1D);
        tests_run++;
        if (cv_cycles - cv0 != 1) begin
            tests_failed++; $display("FAIL make_w_cv: got %0d pulses want 1", cv_cycles - cv0);
        end
        tests_run++;
        if (code_at_cv !== 8'h1D) begin
            tests_failed++; $display("FAIL make_w_code: got %h want 1d", code_at_cv);
        end
        tests_run++;
        if (keys_at_cv !== 4'b0001) begin
            tests_failed++; $display("FAIL make_w_keys_at_cv: got %b want 0001", keys_at_cv);
        end
        tests_run++;
        if ({p2d, p2u, p1d, p1u} !== 4'b0001 || err_cycles != e0) begin
            tests_failed++; $display("FAIL make_w_hold: got keys %b errs %0d want 0001 0", {p2d, p2u, p1d, p1u}, err_cycles - e0);
        end
    endtask

    task automatic test_break_w;
        int cv0;
        cv0 = cv_cycles;
        send_byte(8'hF0);
        tests_run++;
        if (p1u !== 1'b1) begin
            tests_failed++; $display("FAIL break_prefix_p1u: got %b want 1", p1u);
        end
        send_byte(8'h1D);
        tests_run++;
        if (keys_at_cv !== 4'b0000 || code_at_cv !== 8'h1D || cv_cycles - cv0 != 2) begin
            tests_failed++; $display("FAIL break_w: got keys %b code %h pulses %0d want 0000 1d 2", keys_at_cv, code_at_cv, cv_cycles - cv0);
        end
    endtask

    task automatic test_ext_up;
        send_byte(8'hE0);
        send_byte(8'h75);
        tests_run++;
        if ({p2d, p2u, p1d, p1u} !== 4'b0100) begin
            tests_failed++; $display("FAIL ext_up_make: got %b want 0100", {p2d, p2u, p1d, p1u});
        end
        send_byte(8'h75);
        tests_run++;
        if ({p2d, p2u, p1d, p1u} !== 4'b0100 || code_at_cv !== 8'h75) begin
            tests_failed++; $display("FAIL plain_75: got keys %b code %h want 0100 75", {p2d, p2u, p1d, p1u}, code_at_cv);
        end
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h75);
        tests_run++;
        if ({p2d, p2u, p1d, p1u} !== 4'b0000) begin
            tests_failed++; $display("FAIL ext_up_break: got %b want 0000", {p2d, p2u, p1d, p1u});
        end
    endtask

    task automatic test_parity_err;
        int cv0, e0;
        cv0 = cv_cycles; e0 = err_cycles;
        send_bits(mk_frame(8'h1B, 1'b1), 11, 1'b0);
        wait_clk(20);
        tests_run++;
        if (err_cycles - e0 != 1 || cv_cycles != cv0) begin
            tests_failed++; $display("FAIL parity_err: got err %0d cv %0d want 1 0", err_cycles - e0, cv_cycles - cv0);
        end
        tests_run++;
        if (p1d !== 1'b0) begin
            tests_failed++; $display("FAIL parity_p1d: got %b want 0", p1d);
        end
        send_byte(8'h1B);
        tests_run++;
        if ({p2d, p2u, p1d, p1u} !== 4'b0010 || code_at_cv !== 8'h1B) begin
            tests_failed++; $display("FAIL parity_recover: got keys %b code %h want 0010 1b", {p2d, p2u, p1d, p1u}, code_at_cv);
        end
    endtask

    task automatic test_timeout;
        int cv0, e0;
        cv0 = cv_cycles; e0 = err_cycles;
        send_bits(mk_frame(8'h55, 1'b0), 5, 1'b0);
        wait_clk(TO + 200);
        tests_run++;
        if (err_cycles - e0 != 1 || cv_cycles != cv0) begin
            tests_failed++; $display("FAIL timeout_err: got err %0d cv %0d want 1 0", err_cycles - e0, cv_cycles - cv0);
        end
        send_byte(8'hE0);
        send_byte(8'h72);
        tests_run++;
        if ({p2d, p2u, p1d, p1u} !== 4'b1010 || code_at_cv !== 8'h72) begin
            tests_failed++; $display("FAIL timeout_recover: got keys %b code %h want 1010 72", {p2d, p2u, p1d, p1u}, code_at_cv);
        end
    endtask

    task automatic test_glitch;
        int cv0, e0;
        cv0 = cv_cycles; e0 = err_cycles;
        send_bits(mk_frame(8'h1D, 1'b0), 11, 1'b1);
        wait_clk(20);
        tests_run++;
        if (cv_cycles - cv0 != 1 || err_cycles != e0 || code_at_cv !== 8'h1D) begin
            tests_failed++; $display("FAIL glitch_frame: got cv %0d err %0d code %h want 1 0 1d", cv_cycles - cv0, err_cycles - e0, code_at_cv);
        end
        tests_run++;
        if ({p2d, p2u, p1d, p1u} !== 4'b1011) begin
            tests_failed++; $display("FAIL glitch_keys: got %b want 1011", {p2d, p2u, p1d, p1u});
        end
    endtask

    task automatic test_back_to_back;
        int cv0;
        cv0 = cv_cycles;
        send_byte(8'h1D);
        send_byte(8'h1D);
        tests_run++;
        if ({p2d, p2u, p1d, p1u} !== 4'b1011 || cv_cycles - cv0 != 2) begin
            tests_failed++; $display("FAIL typematic: got keys %b pulses %0d want 1011 2", {p2d, p2u, p1d, p1u}, cv_cycles - cv0);
        end
    endtask

    task automatic test_reset_mid;
        int cv0, e0;
        cv0 = cv_cycles; e0 = err_cycles;
        send_bits(mk_frame(8'h1B, 1'b0), 5, 1'b0);
        reset = 1'b0;
        wait_clk(4);
        @(negedge clk);
        tests_run++;
        if ({p2d, p2u, p1d, p1u} !== 4'b0000 || code !== 8'h00) begin
            tests_failed++; $display("FAIL reset_mid_outs: got keys %b code %h want 0000 00", {p2d, p2u, p1d, p1u}, code);
        end
        reset = 1'b1;
        wait_clk(TO + 200);
        tests_run++;
        if (cv_cycles != cv0 || err_cycles != e0) begin
            tests_failed++; $display("FAIL reset_mid_pulses: got cv %0d err %0d want 0 0", cv_cycles - cv0, err_cycles - e0);
        end
        send_byte(8'h1D);
        tests_run++;
        if ({p2d, p2u, p1d, p1u} !== 4'b0001) begin
            tests_failed++; $display("FAIL reset_mid_recover: got %b want 0001", {p2d, p2u, p1d, p1u});
        end
    endtask

    initial begin
        test_reset();
        test_make_w();
        test_break_w();
        test_ext_up();
        test_parity_err();
        test_timeout();
        test_glitch();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
